// File: rtl/mul_pipe_ctrl.sv
// Pipeline registers and control for the E->M->W multiplier stages; an op accepted in cycle N writes back in N+2.
// Stall freezes every stage and writeback; flush kills all in-flight ops; issue_ready mirrors ~stall.
module mul_pipe_ctrl #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [1:0]        issue_op,
    input  logic [RAW-1:0]    issue_rd,
    input  logic              stall,
    input  logic              flush,
    input  logic [2*XLEN-1:0] e_product,
    input  logic              e_negate,
    input  logic [XLEN-1:0]   e_opA,
    input  logic [XLEN-1:0]   e_opB,
    output logic [2*XLEN-1:0] m_product_in,
    output logic              m_negate,
    output logic [XLEN-1:0]   m_opA,
    output logic [XLEN-1:0]   m_opB,
    input  logic [2*XLEN-1:0] m_product_out,
    output logic [2*XLEN-1:0] w_product,
    output logic              w_negate,
    output logic [XLEN-1:0]   w_opA,
    output logic [XLEN-1:0]   w_opB,
    output logic [1:0]        w_op,
    input  logic [XLEN-1:0]   w_result,
    output logic              wb_valid,
    output logic [RAW-1:0]    wb_rd,
    output logic [XLEN-1:0]   wb_data,
    input  logic [RAW-1:0]    src_rs1,
    input  logic [RAW-1:0]    src_rs2,
    output logic              raw_hazard
);

    logic           v_m;
    logic           v_w;
    logic [1:0]     m_op;
    logic [RAW-1:0] m_rd;
    logic [RAW-1:0] w_rd;
    logic           acc;

    assign acc         = issue_valid & ~stall & ~flush;
    assign issue_ready = ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_m          <= 1'b0;
            v_w          <= 1'b0;
            m_product_in <= '0;
            m_negate     <= 1'b0;
            m_opA        <= '0;
            m_opB        <= '0;
            m_op         <= '0;
            m_rd         <= '0;
            w_product    <= '0;
            w_negate     <= 1'b0;
            w_opA        <= '0;
            w_opB        <= '0;
            w_op         <= '0;
            w_rd         <= '0;
        end else if (flush) begin
            // Data registers keep their contents; only the valids matter once flushed.
            v_m <= 1'b0;
            v_w <= 1'b0;
        end else if (!stall) begin
            v_m          <= acc;
            m_product_in <= e_product;
            m_negate     <= e_negate;
            m_opA        <= e_opA;
            m_opB        <= e_opB;
            m_op         <= issue_op;
            m_rd         <= issue_rd;
            v_w          <= v_m;
            w_product    <= m_product_out;
            w_negate     <= m_negate;
            w_opA        <= m_opA;
            w_opB        <= m_opB;
            w_op         <= m_op;
            w_rd         <= m_rd;
        end
    end

    // W holds through a stall, so gating with ~stall yields exactly one write on release.
    assign wb_valid = v_w & ~stall & ~flush & (w_rd != '0);
    assign wb_rd    = w_rd;
    assign wb_data  = w_result;

    // Only M can conflict; the W result is forwarded from wb_data.
    assign raw_hazard = v_m & (m_rd != '0) & ((m_rd == src_rs1) | (m_rd == src_rs2));

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Drives the control shell with a toy split multiplier datapath and compares writeback/hazard outputs
// against an arithmetic reference of in-flight ops.
module tb_mul_pipe_ctrl;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    logic              clk;
    logic              rst;
    logic              issue_valid;
    logic              issue_ready;
    logic [1:0]        issue_op;
    logic [RAW-1:0]    issue_rd;
    logic              stall;
    logic              flush;
    logic [2*XLEN-1:0] e_product;
    logic              e_negate;
    logic [XLEN-1:0]   e_opA, e_opB;
    logic [2*XLEN-1:0] m_product_in;
    logic              m_negate;
    logic [XLEN-1:0]   m_opA, m_opB;
    logic [2*XLEN-1:0] m_product_out;
    logic [2*XLEN-1:0] w_product;
    logic              w_negate;
    logic [XLEN-1:0]   w_opA, w_opB;
    logic [1:0]        w_op;
    logic [XLEN-1:0]   w_result;
    logic              wb_valid;
    logic [RAW-1:0]    wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic [RAW-1:0]    src_rs1, src_rs2;
    logic              raw_hazard;

    logic [XLEN-1:0]   op_a, op_b;

    mul_pipe_ctrl #(.XLEN(XLEN), .RAW(RAW)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_rd(issue_rd),
        .stall(stall), .flush(flush),
        .e_product(e_product), .e_negate(e_negate), .e_opA(e_opA), .e_opB(e_opB),
        .m_product_in(m_product_in), .m_negate(m_negate), .m_opA(m_opA), .m_opB(m_opB),
        .m_product_out(m_product_out),
        .w_product(w_product), .w_negate(w_negate), .w_opA(w_opA), .w_opB(w_opB), .w_op(w_op),
        .w_result(w_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .src_rs1(src_rs1), .src_rs2(src_rs2), .raw_hazard(raw_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy datapath: E multiplies the low half of |A|, M adds the high half, W applies sign and selects the half.
    logic        e_sa, e_sb;
    logic [31:0] e_ua, e_ub;
    always_comb begin
        e_sa = (issue_op == 2'd1) || (issue_op == 2'd2);
        e_sb = (issue_op == 2'd1);
        e_ua = (e_sa && op_a[31]) ? -op_a : op_a;
        e_ub = (e_sb && op_b[31]) ? -op_b : op_b;
        e_negate  = (e_sa & op_a[31]) ^ (e_sb & op_b[31]);
        e_opA     = e_ua;
        e_opB     = e_ub;
        e_product = {48'b0, e_ua[15:0]} * {32'b0, e_ub};
    end

    always_comb begin
        m_product_out = m_product_in + (({48'b0, m_opA[31:16]} * {32'b0, m_opB}) << 16);
    end

    logic [63:0] w_signed;
    always_comb begin
        w_signed = w_negate ? -w_product : w_product;
        w_result = (w_op == 2'd0) ? w_signed[31:0] : w_signed[63:32];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        case (op)
            2'd0: p = $signed({32'b0, a}) * $signed({32'b0, b});
            2'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            2'd2: p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
            default: p = $signed({32'b0, a}) * $signed({32'b0, b});
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Reference: slot 0 is the op one cycle after issue, slot 1 the op two cycles after issue.
    logic        sv  [2];
    logic [4:0]  srd [2];
    logic [31:0] sres[2];
    logic [31:0] wb_log[$];
    logic        obs_hz;
    logic [31:0] obs_wd;

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0; srd[i] = '0; sres[i] = '0;
        end
    endtask

    task automatic cyc(input logic iv, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic st, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2);
        logic exp_wv, exp_hz;
        issue_valid = iv; issue_op = op; op_a = a; op_b = b; issue_rd = rd;
        stall = st; flush = fl; src_rs1 = r1; src_rs2 = r2;
        @(negedge clk);
        exp_wv = sv[1] && !st && !fl && (srd[1] != 0);
        exp_hz = sv[0] && (srd[0] != 0) && (srd[0] == r1 || srd[0] == r2);
        chk("wb_valid", wb_valid, exp_wv);
        if (exp_wv) begin
            chk("wb_rd", wb_rd, srd[1]);
            chk("wb_data", wb_data, sres[1]);
        end
        chk("raw_hazard", raw_hazard, exp_hz);
        chk("issue_ready", issue_ready, !st);
        obs_hz = raw_hazard;
        obs_wd = wb_data;
        if (wb_valid) wb_log.push_back(wb_data);
        if (fl) begin
            sv[0] = 1'b0; sv[1] = 1'b0;
        end else if (!st) begin
            sv[1] = sv[0]; srd[1] = srd[0]; sres[1] = sres[0];
            sv[0] = iv; srd[0] = rd; sres[0] = ref_mul(op, a, b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_op = '0; issue_rd = '0; op_a = '0; op_b = '0;
        stall = 1'b0; flush = 1'b0; src_rs1 = '0; src_rs2 = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_hazard", raw_hazard, 1'b0);
        chk("rst_w_product", w_product, 64'd0);
        chk("rst_w_op", w_op, 2'd0);
        chk("rst_m_opA", m_opA, 32'd0);
        rst = 1'b0;

        // Single MUL: written once, two cycles after issue.
        wb_log.delete();
        cyc(1'b1, 2'd0, 32'd2, 32'd3, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(4);
        chk("t1_count", wb_log.size(), 1);
        if (wb_log.size() > 0) chk("t1_data", wb_log[0], 32'd6);

        // Back-to-back mixed ops.
        wb_log.delete();
        cyc(1'b1, 2'd0, 32'd2, 32'd3, 5'd1, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 2'd1, 32'd2, 32'd3, 5'd2, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 2'd2, 32'hFFFF_FFFE, 32'd3, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 2'd3, 32'd2, 32'd3, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(3);
        chk("b2b_count", wb_log.size(), 4);
        if (wb_log.size() == 4) begin
            chk("b2b_mul", wb_log[0], 32'd6);
            chk("b2b_mulh", wb_log[1], 32'd0);
            chk("b2b_mulhsu", wb_log[2], 32'hFFFF_FFFF);
            chk("b2b_mulhu", wb_log[3], 32'd0);
        end

        // Stall three cycles while the op sits in W.
        wb_log.delete();
        cyc(1'b1, 2'd0, 32'd7, 32'd9, 5'd8, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
        idle(3);
        chk("stall_count", wb_log.size(), 1);
        if (wb_log.size() > 0) chk("stall_data", wb_log[0], 32'd63);

        // Flush kills two in-flight ops; the next op still writes.
        wb_log.delete();
        cyc(1'b1, 2'd0, 32'd5, 32'd5, 5'd10, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 2'd0, 32'd6, 32'd6, 5'd11, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0);
        cyc(1'b1, 2'd0, 32'd3, 32'd4, 5'd12, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(3);
        chk("flush_count", wb_log.size(), 1);
        if (wb_log.size() > 0) chk("flush_next", wb_log[0], 32'd12);

        // rd = x0 never writes and never flags a hazard.
        wb_log.delete();
        cyc(1'b1, 2'd0, 32'd4, 32'd4, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("x0_hazard", obs_hz, 1'b0);
        idle(3);
        chk("x0_count", wb_log.size(), 0);

        // Hazard against M, cleared once the op reaches W.
        cyc(1'b1, 2'd0, 32'd5, 32'd6, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
        chk("hz_n1", obs_hz, 1'b1);
        cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
        chk("hz_n2", obs_hz, 1'b0);
        chk("hz_n2_data", obs_wd, 32'd30);

        // Hazard held across a stall.
        cyc(1'b1, 2'd0, 32'd5, 32'd6, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd7);
        chk("hz_stall1", obs_hz, 1'b1);
        cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd7);
        chk("hz_stall2", obs_hz, 1'b1);
        cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
        chk("hz_release", obs_hz, 1'b1);
        cyc(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
        chk("hz_advanced", obs_hz, 1'b0);
        idle(2);

        // Asynchronous reset with ops in M and W.
        wb_log.delete();
        cyc(1'b1, 2'd0, 32'd3, 32'd3, 5'd9, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 2'd1, 32'd3, 32'd3, 5'd6, 1'b0, 1'b0, 5'd0, 5'd0);
        src_rs1 = 5'd6;
        rst = 1'b1;
        #1;
        chk("arst_wb_valid", wb_valid, 1'b0);
        chk("arst_hazard", raw_hazard, 1'b0);
        chk("arst_w_product", w_product, 64'd0);
        chk("arst_m_opB", m_opB, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        chk("arst_count", wb_log.size(), 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                2'($urandom_range(0, 3)), $urandom, $urandom,
                5'($urandom_range(0, 7)),
                ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
                ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
